// File: rtl/alu_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq_if : request/response bus of the sequential ALU
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       command;
  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, command, operandA, operandB, out_ready,
    input  in_ready, out_valid, result, carryout, overflow, zero, illegal
  );

  modport slave (
    input  in_valid, command, operandA, operandB, out_ready,
    output in_ready, out_valid, result, carryout, overflow, zero, illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_seq  : handshaked ALU, registered result, iterative shifts; multiply
//            is compiled only when ALU_SEQ_MUL_EN is defined
// Revision : 1.0
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  wire logic clk,
  input  wire logic rst_n,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_NAND = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam int         CW      = SHW + 1;
`else
  localparam int         CW      = SHW;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             cmsb;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_arith;
  logic             alu_ill;
  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             go_busy;
  logic [WIDTH-1:0] step;

  // Single-cycle datapath works straight off the bus so it can be registered
  // on the handshake edge itself.
  always_comb begin
    sub          = (bus.command != OP_ADD);
    b_eff        = sub ? ~bus.operandB : bus.operandB;
    {cout, sum}  = {1'b0, bus.operandA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    cmsb         = bus.operandA[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];
    add_ovf      = cmsb ^ cout;
    amt          = bus.operandB[SHW-1:0];
    alu_res      = '0;
    alu_arith    = 1'b0;
    alu_ill      = 1'b0;
    is_shift     = 1'b0;
    case (bus.command)
      OP_ADD, OP_SUB: begin
        alu_res   = sum;
        alu_arith = 1'b1;
      end
      OP_XOR:  alu_res = bus.operandA ^ bus.operandB;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      OP_AND:  alu_res = bus.operandA & bus.operandB;
      OP_NAND: alu_res = ~(bus.operandA & bus.operandB);
      OP_NOR:  alu_res = ~(bus.operandA | bus.operandB);
      OP_OR:   alu_res = bus.operandA | bus.operandB;
      OP_SLL, OP_SRL, OP_SRA: begin
        alu_res  = bus.operandA;
        is_shift = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
    go_busy = is_shift && (amt != '0);
`ifdef ALU_SEQ_MUL_EN
    if (bus.command == OP_MUL) go_busy = 1'b1;
`endif
  end

  // One iteration of whichever multi-cycle operation is in flight.
  always_comb begin
    step = acc_q;
    case (op_q)
      OP_SLL:  step = acc_q << 1;
      OP_SRL:  step = acc_q >> 1;
      OP_SRA:  step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
      default: step = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
`ifdef ALU_SEQ_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.command;
          if (go_busy) begin
            state_d = S_BUSY;
            acc_d   = bus.operandA;
            cnt_d   = CW'(amt);
`ifdef ALU_SEQ_MUL_EN
            if (bus.command == OP_MUL) begin
              acc_d    = '0;
              cnt_d    = CW'(WIDTH);
              mcand_d  = bus.operandA;
              mplier_d = bus.operandB;
            end
`endif
          end else begin
            state_d   = S_DONE;
            result_d  = alu_res;
            carry_d   = alu_arith & cout;
            ovf_d     = alu_arith & add_ovf;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
          end
        end
      end
      S_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`endif
        if (cnt_q == CW'(1)) begin
          state_d   = S_DONE;
          result_d  = step;
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          zero_d    = (step == '0);
          illegal_d = 1'b0;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.carryout  = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_seq : directed vectors with a result scoreboard for alu_seq
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string       nm;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
    logic        ill;
    int          lat;
    int          hs;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare on each new result presented by the DUT.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%08h with no request pending", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, ".result"},   bus.result, e.r);
        chk({e.nm, ".carryout"}, {31'b0, bus.carryout}, {31'b0, e.c});
        chk({e.nm, ".overflow"}, {31'b0, bus.overflow}, {31'b0, e.o});
        chk({e.nm, ".zero"},     {31'b0, bus.zero},     {31'b0, e.z});
        chk({e.nm, ".illegal"},  {31'b0, bus.illegal},  {31'b0, e.ill});
        chk({e.nm, ".latency"},  32'(cyc - e.hs + 1),   32'(e.lat));
      end
    end
    prev_v = rst_n && bus.out_valid;
  end

  task automatic send(input string nm, input logic [3:0] cmd, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input logic c,
                      input logic o, input logic z, input logic ill, input int lat);
    exp_t e;
    bit   hs;
    hs = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.command  = cmd;
    bus.operandA = a;
    bus.operandB = b;
    for (int i = 0; i < 200 && !hs; i++) begin
      if (i > 0) @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
    end
    #1;
    if (!hs) begin
      n_chk++;
      n_err++;
      $display("FAIL %s.handshake: got in_ready=0 for 200 cycles expected 1", nm);
    end else begin
      e.nm = nm; e.r = r; e.c = c; e.o = o; e.z = z; e.ill = ill; e.lat = lat; e.hs = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (sb.size() == 0);
    end
    if (!done) begin
      n_chk++;
      n_err++;
      $display("FAIL %s.timeout: got %0d pending results expected 0", nm, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string nm);
    chk({nm, ".in_ready"},  {31'b0, bus.in_ready},  32'd1);
    chk({nm, ".out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({nm, ".result"},    bus.result,             32'd0);
    chk({nm, ".carryout"},  {31'b0, bus.carryout},  32'd0);
    chk({nm, ".overflow"},  {31'b0, bus.overflow},  32'd0);
    chk({nm, ".zero"},      {31'b0, bus.zero},      32'd1);
    chk({nm, ".illegal"},   {31'b0, bus.illegal},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.command   = 4'd0;
    bus.operandA  = 32'd0;
    bus.operandB  = 32'd0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    //     name        cmd    A             B             result        c     o     z     ill   lat
    send("add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0, 1);  drain("add_ovf");
    send("sub_eq",   4'd1,  32'd5,        32'd5,        32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1);  drain("sub_eq");
    send("sub_brw",  4'd1,  32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("sub_brw");
    send("add_wrap", 4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0, 1);  drain("add_wrap");
    send("slt",      4'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("slt");
    send("xor",      4'd2,  32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("xor");
    send("and",      4'd4,  32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("and");
    send("nand",     4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1);  drain("nand");
    send("nor",      4'd6,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("nor");
    send("or",       4'd7,  32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("or");
    send("sra4",     4'd10, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 1'b0, 1'b0, 5);  drain("sra4");
    send("sll0",     4'd8,  32'h12345678, 32'd0,        32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 1);  drain("sll0");
    send("srl31",    4'd9,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 32); drain("srl31");
    send("sll_hib",  4'd8,  32'h00000001, 32'h00000025, 32'h00000020, 1'b0, 1'b0, 1'b0, 1'b0, 6);  drain("sll_hib");
    send("resv13",   4'd13, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1);  drain("resv13");
`ifdef ALU_SEQ_MUL_EN
    send("mul",      4'd11, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 33); drain("mul");
`else
    send("mul_off",  4'd11, 32'h0000FFFF, 32'h00010001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 1);  drain("mul_off");
`endif

    // Back-pressure: result must hold while a competing request is ignored.
    bus.out_ready = 1'b0;
    send("bp_add", 4'd0, 32'h10, 32'h20, 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain("bp_add");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.command  = 4'd1;
      bus.operandA = 32'h55;
      bus.operandB = 32'h11;
      #1;
      chk("bp_hold.result",    bus.result,              32'h30);
      chk("bp_hold.in_ready",  {31'b0, bus.in_ready},   32'd0);
      chk("bp_hold.out_valid", {31'b0, bus.out_valid},  32'd1);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Abort an in-flight multi-cycle operation with reset.
`ifdef ALU_SEQ_MUL_EN
    send("abort_mul", 4'd11, 32'h12345678, 32'h87654321, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33);
`else
    send("abort_sll", 4'd8,  32'h00000001, 32'd20,       32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 21);
`endif
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    send("post_add", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    drain("post_add");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU. Keeps the eight-command encoding and the carryout/zero/overflow flags. Adds a registered result, valid/ready flow control and iterative multi-cycle shift and multiply operations. Sits between the operand register file and writeback in the multi-cycle datapath; one operation in flight at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, ≥ 4
- SHW, $clog2(WIDTH), shift-amount field width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- command  in  4  operation code
- operandA  in  WIDTH  first operand
- operandB  in  WIDTH  second operand / shift amount
- out_valid  out  1  result registers hold a completed operation
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- carryout  out  1  carry out of MSB (ADD/SUB only, else 0)
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- zero  out  1  result == 0
- illegal  out  1  command was reserved/unsupported

## Operation
- Command codes:
  - 0 ADD
  - 1 SUB
  - 2 XOR
  - 3 SLT
  - 4 AND
  - 5 NAND
  - 6 NOR
  - 7 OR
  - 8 SLL
  - 9 SRL
  - 10 SRA
  - 11 MUL
  - 12–15 reserved
- Operands and command are captured into internal registers on the handshake (in_valid && in_ready); inputs are don't-care afterwards.
- FSM states:
  - IDLE: in_ready=1. Handshake with a single-cycle op (0–7, reserved, shift with amount 0) → DONE. Handshake with a shift of amount > 0, or MUL → BUSY.
  - BUSY: one iteration per cycle. Counter reaching its terminal count → DONE.
  - DONE: out_valid=1. out_ready=1 → IDLE.
- SUB computes A + ~B + 1; carryout=1 means no borrow. Overflow = carry into MSB XOR carry out of MSB.
- SLT: result = {WIDTH-1 zeros, (A−B)[MSB] XOR overflow}, i.e. signed less-than. Flags are 0.
- Logic ops are bitwise over WIDTH bits.
- Shifts: amount = operandB[SHW-1:0]. Shift by one bit per cycle for exactly amount cycles. SRA replicates the MSB.
- MUL: shift-add, unsigned, WIDTH iterations. Result is the low WIDTH bits of A×B.
- Reserved codes: result 0, illegal=1, zero=1.
- zero, carryout, overflow and illegal are registered with result and are valid whenever out_valid=1.

## Timing
- Reset (async assert, sync deassert handled externally):
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - result = 0
  - carryout = overflow = illegal = 0
  - zero = 1
  - counter = 0
- Reset asserted mid-BUSY or mid-DONE aborts the operation; no result is produced.
- Latency from handshake edge to out_valid:
  - single-cycle ops: 1 cycle
  - shift by n > 0: n+1 cycles
  - MUL: WIDTH+1 cycles
- in_ready is 0 in BUSY and DONE. No request is accepted until the DONE result is consumed. There is no same-cycle result-drain-and-accept.
- In DONE with out_ready=0, result and flags hold stable indefinitely.
- in_valid while BUSY/DONE is ignored. The requester must hold in_valid until in_ready.
- Shift amount WIDTH-1 is the maximum; larger operandB bits above SHW are ignored.

## Configuration
- ALU_SEQ_MUL_EN:
  - Defined: code 11 performs MUL as above.
  - Undefined: multiplier datapath and its counter width are not compiled. Code 11 behaves as reserved (1-cycle, result 0, illegal=1).

## Test plan
- Reset then ADD 0x7FFFFFFF + 0x00000001 → out_valid 1 cycle after handshake; result 0x80000000, overflow=1, carryout=0, zero=0.
- SUB 5 − 5 → result 0, zero=1, carryout=1. SLT 0xFFFFFFFF vs 0x00000001 → result 1.
- SRA 0x80000000 by 4 → out_valid exactly 5 cycles after handshake; result 0xF8000000. SLL by 0 → 1-cycle latency, result = A.
- MUL 0x0000FFFF × 0x00010001 (macro on) → result 0xFFFFFFFF after 33 cycles. With macro off → result 0, illegal=1 after 1 cycle.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0. Drive a new in_valid during the hold → ignored.
- Assert rst_n=0 during MUL iteration 10 → outputs return to reset values immediately. After release, next ADD 2+3 → 5.
